// File: rtl/z16_mem_arbiter.sv
// Round-robin arbiter sharing the Z16 data memory between the CPU (port 0) and
// the boot loader / debug host (port 1), with a watchdog-bounded port-1 lock.
module z16_mem_arbiter #(
    parameter int READ_LAT = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_p0_req,
    input  logic        i_p0_wen,
    input  logic [15:0] i_p0_addr,
    input  logic [15:0] i_p0_wdata,
    output logic        o_p0_gnt,
    output logic        o_p0_rvalid,
    output logic [15:0] o_p0_rdata,
    output logic        o_cpu_stall,

    input  logic        i_p1_req,
    input  logic        i_p1_wen,
    input  logic        i_p1_lock,
    input  logic [15:0] i_p1_addr,
    input  logic [15:0] i_p1_wdata,
    output logic        o_p1_gnt,
    output logic        o_p1_rvalid,
    output logic [15:0] o_p1_rdata,

    output logic        o_mem_en,
    output logic        o_mem_wen,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata
);

    localparam int              CW      = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(LOCK_MAX);

    logic                r_last;      // port accepted most recently
    logic                r_locked;
    logic [CW-1:0]       r_lock_cnt;
    logic [READ_LAT-1:0] r_pipe_vld;
    logic [READ_LAT-1:0] r_pipe_id;

    logic lock_active;
    logic p0_gnt;
    logic p1_gnt;
    logic rd_accept;
    logic head_vld;
    logic head_id;

    // Once the watchdog count is reached the lock stops steering arbitration;
    // port 1 was necessarily the last winner, so a tie now goes to port 0.
    assign lock_active = r_locked && (r_lock_cnt < CNT_MAX);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (lock_active) begin
            p1_gnt = i_p1_req;
        end else if (i_p0_req && i_p1_req) begin
            p0_gnt = r_last;
            p1_gnt = ~r_last;
        end else begin
            p0_gnt = i_p0_req;
            p1_gnt = i_p1_req;
        end
    end

    assign o_p0_gnt    = p0_gnt;
    assign o_p1_gnt    = p1_gnt;
    assign o_cpu_stall = i_p0_req & ~p0_gnt;

    always_comb begin
        o_mem_en    = p0_gnt | p1_gnt;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (p0_gnt) begin
            o_mem_wen   = i_p0_wen;
            o_mem_addr  = i_p0_addr;
            o_mem_wdata = i_p0_wdata;
        end else if (p1_gnt) begin
            o_mem_wen   = i_p1_wen;
            o_mem_addr  = i_p1_addr;
            o_mem_wdata = i_p1_wdata;
        end
    end

    assign rd_accept = (p0_gnt & ~i_p0_wen) | (p1_gnt & ~i_p1_wen);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last     <= 1'b1;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            if (p0_gnt) begin
                r_last     <= 1'b0;
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end else if (p1_gnt) begin
                r_last <= 1'b1;
                if (i_p1_lock) begin
                    r_locked <= 1'b1;
                    if (r_lock_cnt != CNT_MAX) begin
                        r_lock_cnt <= r_lock_cnt + CW'(1);
                    end
                end else begin
                    r_locked   <= 1'b0;
                    r_lock_cnt <= '0;
                end
            end

            // Tag pipe: stage 0 holds reads accepted last cycle, the top stage
            // lines up with i_mem_rdata.
            for (int i = READ_LAT - 1; i > 0; i--) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
            r_pipe_vld[0] <= rd_accept;
            r_pipe_id[0]  <= p1_gnt;
        end
    end

    assign head_vld = r_pipe_vld[READ_LAT-1];
    assign head_id  = r_pipe_id[READ_LAT-1];

    assign o_p0_rvalid = head_vld & ~head_id;
    assign o_p1_rvalid = head_vld & head_id;
    assign o_p0_rdata  = o_p0_rvalid ? i_mem_rdata : 16'h0000;
    assign o_p1_rdata  = o_p1_rvalid ? i_mem_rdata : 16'h0000;

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Directed bench for z16_mem_arbiter: instance a uses READ_LAT=1, instance b
// READ_LAT=3; both share stimulus and are checked against hand-computed values.
module tb_z16_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_wen;
    logic [15:0] p0_addr, p0_wdata;
    logic        p1_req, p1_wen, p1_lock;
    logic [15:0] p1_addr, p1_wdata;
    logic [15:0] mem_rdata;

    logic        a_p0_gnt, a_p0_rvalid, a_cpu_stall, a_p1_gnt, a_p1_rvalid;
    logic        a_mem_en, a_mem_wen;
    logic [15:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata;
    logic        b_p0_gnt, b_p0_rvalid, b_cpu_stall, b_p1_gnt, b_p1_rvalid;
    logic        b_mem_en, b_mem_wen;
    logic [15:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata;

    logic [70:0] a_all, b_all;
    assign a_all = {a_p0_gnt, a_p0_rvalid, a_p0_rdata, a_cpu_stall, a_p1_gnt, a_p1_rvalid,
                    a_p1_rdata, a_mem_en, a_mem_wen, a_mem_addr, a_mem_wdata};
    assign b_all = {b_p0_gnt, b_p0_rvalid, b_p0_rdata, b_cpu_stall, b_p1_gnt, b_p1_rvalid,
                    b_p1_rdata, b_mem_en, b_mem_wen, b_mem_addr, b_mem_wdata};

    int n_pass  = 0;
    int n_total = 0;

    z16_mem_arbiter #(.READ_LAT(1), .LOCK_MAX(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p0_req(p0_req), .i_p0_wen(p0_wen), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .o_p0_gnt(a_p0_gnt), .o_p0_rvalid(a_p0_rvalid), .o_p0_rdata(a_p0_rdata),
        .o_cpu_stall(a_cpu_stall),
        .i_p1_req(p1_req), .i_p1_wen(p1_wen), .i_p1_lock(p1_lock), .i_p1_addr(p1_addr),
        .i_p1_wdata(p1_wdata),
        .o_p1_gnt(a_p1_gnt), .o_p1_rvalid(a_p1_rvalid), .o_p1_rdata(a_p1_rdata),
        .o_mem_en(a_mem_en), .o_mem_wen(a_mem_wen), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    z16_mem_arbiter #(.READ_LAT(3), .LOCK_MAX(16)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p0_req(p0_req), .i_p0_wen(p0_wen), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .o_p0_gnt(b_p0_gnt), .o_p0_rvalid(b_p0_rvalid), .o_p0_rdata(b_p0_rdata),
        .o_cpu_stall(b_cpu_stall),
        .i_p1_req(p1_req), .i_p1_wen(p1_wen), .i_p1_lock(p1_lock), .i_p1_addr(p1_addr),
        .i_p1_wdata(p1_wdata),
        .o_p1_gnt(b_p1_gnt), .o_p1_rvalid(b_p1_rvalid), .o_p1_rdata(b_p1_rdata),
        .o_mem_en(b_mem_en), .o_mem_wen(b_mem_wen), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        p0_req = 0; p0_wen = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_wen = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
        mem_rdata = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        n_total++;
        if (a_all !== '0) $display("FAIL reset_outputs_a: got %h expected 0", a_all);
        else n_pass++;
        n_total++;
        if (b_all !== '0) $display("FAIL reset_outputs_b: got %h expected 0", b_all);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_single_read();
        p0_req = 1; p0_wen = 0; p0_addr = 16'h0010;
        @(negedge clk);
        n_total++;
        if ({a_p0_gnt, a_p1_gnt, a_cpu_stall, a_mem_en, a_mem_wen} !== 5'b10010)
            $display("FAIL p0_read_grant: got %b expected 10010",
                     {a_p0_gnt, a_p1_gnt, a_cpu_stall, a_mem_en, a_mem_wen});
        else n_pass++;
        n_total++;
        if (a_mem_addr !== 16'h0010) $display("FAIL p0_read_addr: got %h expected 0010", a_mem_addr);
        else n_pass++;
        step();
        idle_inputs();
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        n_total++;
        if ({a_p0_rvalid, a_p0_rdata} !== {1'b1, 16'hBEEF})
            $display("FAIL p0_read_return: got %b/%h expected 1/beef", a_p0_rvalid, a_p0_rdata);
        else n_pass++;
        n_total++;
        if ({a_p1_rvalid, a_p1_rdata} !== 17'h0)
            $display("FAIL p0_read_other_port: got %b/%h expected 0/0000", a_p1_rvalid, a_p1_rdata);
        else n_pass++;
        step();
    endtask

    task automatic test_round_robin();
        logic exp_p0, prev_p0;
        logic [15:0] exp_data;
        reset_dut();
        p0_wen = 0; p0_addr = 16'h0100;
        p1_wen = 0; p1_addr = 16'h0200;
        for (int i = 0; i < 5; i++) begin
            p0_req = (i < 4);
            p1_req = (i < 4);
            exp_data = 16'h1000 + 16'(i);
            mem_rdata = exp_data;
            @(negedge clk);
            if (i < 4) begin
                exp_p0 = (i % 2 == 0);
                n_total++;
                if ({a_p0_gnt, a_p1_gnt, a_cpu_stall} !== {exp_p0, ~exp_p0, ~exp_p0})
                    $display("FAIL rr_grant[%0d]: got %b expected %b", i,
                             {a_p0_gnt, a_p1_gnt, a_cpu_stall}, {exp_p0, ~exp_p0, ~exp_p0});
                else n_pass++;
                n_total++;
                if (a_mem_addr !== (exp_p0 ? 16'h0100 : 16'h0200))
                    $display("FAIL rr_addr[%0d]: got %h expected %h", i, a_mem_addr,
                             exp_p0 ? 16'h0100 : 16'h0200);
                else n_pass++;
            end
            if (i > 0) begin
                prev_p0 = ((i - 1) % 2 == 0);
                n_total++;
                if ({a_p0_rvalid, a_p1_rvalid} !== {prev_p0, ~prev_p0})
                    $display("FAIL rr_rvalid[%0d]: got %b expected %b", i,
                             {a_p0_rvalid, a_p1_rvalid}, {prev_p0, ~prev_p0});
                else n_pass++;
                n_total++;
                if ({a_p0_rdata, a_p1_rdata} !== (prev_p0 ? {exp_data, 16'h0} : {16'h0, exp_data}))
                    $display("FAIL rr_rdata[%0d]: got %h/%h expected data %h on p%0d", i,
                             a_p0_rdata, a_p1_rdata, exp_data, prev_p0 ? 0 : 1);
                else n_pass++;
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        reset_dut();
        p1_req = 1; p1_wen = 1; p1_lock = 1; p1_addr = 16'h0020; p1_wdata = 16'h1234;
        @(negedge clk);
        n_total++;
        if ({a_p1_gnt, a_mem_wen, a_mem_addr, a_mem_wdata} !== {2'b11, 16'h0020, 16'h1234})
            $display("FAIL lock_first_write: got %b%b %h %h expected 11 0020 1234",
                     a_p1_gnt, a_mem_wen, a_mem_addr, a_mem_wdata);
        else n_pass++;
        step();
        p0_req = 1; p0_wen = 1; p0_addr = 16'h0030;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++;
            if ({a_p0_gnt, a_p1_gnt, a_cpu_stall} !== 3'b011)
                $display("FAIL lock_hold[%0d]: got %b expected 011", i, {a_p0_gnt, a_p1_gnt, a_cpu_stall});
            else n_pass++;
            step();
        end
        p1_req = 0;
        @(negedge clk);
        n_total++;
        if ({a_p0_gnt, a_cpu_stall, a_mem_en} !== 3'b010)
            $display("FAIL lock_p1_idle: got %b expected 010", {a_p0_gnt, a_cpu_stall, a_mem_en});
        else n_pass++;
        step();
        p1_req = 1; p1_lock = 0;
        @(negedge clk);
        n_total++;
        if ({a_p0_gnt, a_p1_gnt, a_cpu_stall} !== 3'b011)
            $display("FAIL lock_release: got %b expected 011", {a_p0_gnt, a_p1_gnt, a_cpu_stall});
        else n_pass++;
        step();
        p1_req = 0;
        @(negedge clk);
        n_total++;
        if ({a_p0_gnt, a_cpu_stall, a_mem_addr} !== {2'b10, 16'h0030})
            $display("FAIL lock_after_release: got %b%b %h expected 10 0030",
                     a_p0_gnt, a_cpu_stall, a_mem_addr);
        else n_pass++;
        step();
        idle_inputs();
    endtask

    task automatic test_watchdog();
        int n_p0 = 0;
        int n_p1 = 0;
        reset_dut();
        p1_req = 1; p1_wen = 1; p1_lock = 1; p1_addr = 16'h0040;
        p0_wen = 1; p0_addr = 16'h0050;
        for (int i = 0; i < 16; i++) begin
            p0_req = (i > 0);
            @(negedge clk);
            n_p0 += int'(a_p0_gnt);
            n_p1 += int'(a_p1_gnt);
            step();
        end
        n_total++;
        if (n_p1 !== 16 || n_p0 !== 0)
            $display("FAIL wd_locked_accepts: got p1=%0d p0=%0d expected p1=16 p0=0", n_p1, n_p0);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({a_p0_gnt, a_p1_gnt, a_cpu_stall} !== 3'b100)
            $display("FAIL wd_break: got %b expected 100", {a_p0_gnt, a_p1_gnt, a_cpu_stall});
        else n_pass++;
        step();
        p1_req = 0;
        @(negedge clk);
        n_total++;
        if (a_p0_gnt !== 1'b1) $display("FAIL wd_unlocked: got %b expected 1", a_p0_gnt);
        else n_pass++;
        step();
        p0_req = 0; p1_req = 1;
        step();
        p0_req = 1;
        @(negedge clk);
        n_total++;
        if ({a_p0_gnt, a_p1_gnt} !== 2'b01)
            $display("FAIL wd_relock_count: got %b expected 01", {a_p0_gnt, a_p1_gnt});
        else n_pass++;
        step();
        idle_inputs();
    endtask

    task automatic test_read_lat3();
        reset_dut();
        p0_req = 1; p0_wen = 0; p0_addr = 16'h0002;
        @(negedge clk);
        n_total++;
        if ({b_p0_gnt, b_mem_addr} !== {1'b1, 16'h0002})
            $display("FAIL lat3_p0_issue: got %b %h expected 1 0002", b_p0_gnt, b_mem_addr);
        else n_pass++;
        step();
        p0_req = 0; p1_req = 1; p1_wen = 0; p1_addr = 16'h0004;
        @(negedge clk);
        n_total++;
        if ({b_p1_gnt, b_mem_addr} !== {1'b1, 16'h0004})
            $display("FAIL lat3_p1_issue: got %b %h expected 1 0004", b_p1_gnt, b_mem_addr);
        else n_pass++;
        step();
        idle_inputs();
        @(negedge clk);
        n_total++;
        if ({b_p0_rvalid, b_p1_rvalid} !== 2'b00)
            $display("FAIL lat3_early: got %b expected 00", {b_p0_rvalid, b_p1_rvalid});
        else n_pass++;
        step();
        mem_rdata = 16'hAAAA;
        @(negedge clk);
        n_total++;
        if ({b_p0_rvalid, b_p1_rvalid, b_p0_rdata, b_p1_rdata} !== {2'b10, 16'hAAAA, 16'h0000})
            $display("FAIL lat3_p0_return: got %b%b %h %h expected 10 aaaa 0000",
                     b_p0_rvalid, b_p1_rvalid, b_p0_rdata, b_p1_rdata);
        else n_pass++;
        step();
        mem_rdata = 16'h5555;
        @(negedge clk);
        n_total++;
        if ({b_p0_rvalid, b_p1_rvalid, b_p0_rdata, b_p1_rdata} !== {2'b01, 16'h0000, 16'h5555})
            $display("FAIL lat3_p1_return: got %b%b %h %h expected 01 0000 5555",
                     b_p0_rvalid, b_p1_rvalid, b_p0_rdata, b_p1_rdata);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if ({b_p0_rvalid, b_p1_rvalid} !== 2'b00)
            $display("FAIL lat3_drained: got %b expected 00", {b_p0_rvalid, b_p1_rvalid});
        else n_pass++;
        step();
        idle_inputs();
    endtask

    task automatic test_reset_in_flight();
        reset_dut();
        p0_req = 1; p0_wen = 0; p0_addr = 16'h0002;
        step();
        p0_req = 0; p1_req = 1; p1_wen = 0; p1_addr = 16'h0004;
        step();
        idle_inputs();
        mem_rdata = 16'hFFFF;
        rst_n = 0;
        #2;
        n_total++;
        if (b_all !== '0) $display("FAIL midreset_outputs_b: got %h expected 0", b_all);
        else n_pass++;
        n_total++;
        if (a_all !== '0) $display("FAIL midreset_outputs_a: got %h expected 0", a_all);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if ({b_p0_rvalid, b_p1_rvalid} !== 2'b00)
                $display("FAIL midreset_dropped[%0d]: got %b expected 00", i, {b_p0_rvalid, b_p1_rvalid});
            else n_pass++;
            step();
        end
        p0_req = 1; p1_req = 1; p0_wen = 1; p1_wen = 1;
        @(negedge clk);
        n_total++;
        if ({b_p0_gnt, b_p1_gnt} !== 2'b10)
            $display("FAIL midreset_first_tie: got %b expected 10", {b_p0_gnt, b_p1_gnt});
        else n_pass++;
        step();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_watchdog();
        test_read_lat3();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/z16_mem_arbiter.md
Name: z16_mem_arbiter

Overview:
- Shares the single-port Z16 data memory between two requesters: port 0 is the CPU load/store path, port 1 is the boot loader / debug host.
- Arbitration is round-robin. Port 1 may lock the memory for bursts, and a watchdog bounds that lock.
- Read data returns after a fixed latency, tagged back to the port that issued the read.
- Sits between the CPU datapath and the data memory. It generates the CPU stall when port 0 loses arbitration.

Parameters:
- READ_LAT, 1, memory read latency in cycles (legal 1..4).
- LOCK_MAX, 16, maximum consecutive locked port-1 accepts before the lock is forcibly broken.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_p0_req  in  1  CPU requests an access this cycle.
- i_p0_wen  in  1  CPU access is a write (1) or read (0).
- i_p0_addr  in  16  CPU address.
- i_p0_wdata  in  16  CPU write data.
- o_p0_gnt  out  1  CPU access accepted this cycle.
- o_p0_rvalid  out  1  CPU read data valid.
- o_p0_rdata  out  16  CPU read data.
- o_cpu_stall  out  1  equals i_p0_req & ~o_p0_gnt.
- i_p1_req  in  1  loader requests an access.
- i_p1_wen  in  1  loader access is a write.
- i_p1_lock  in  1  loader asks to keep the memory after this access.
- i_p1_addr  in  16  loader address.
- i_p1_wdata  in  16  loader write data.
- o_p1_gnt  out  1  loader access accepted this cycle.
- o_p1_rvalid  out  1  loader read data valid.
- o_p1_rdata  out  16  loader read data.
- o_mem_en  out  1  memory command valid.
- o_mem_wen  out  1  memory write enable.
- o_mem_addr  out  16  memory address.
- o_mem_wdata  out  16  memory write data.
- i_mem_rdata  in  16  memory read data, valid READ_LAT cycles after a read command.

Behaviour:
- Reset (i_rst_n=0, async):
  - All outputs 0; o_cpu_stall follows its equation.
  - r_last=1, so port 0 wins the first tie.
  - r_locked=0, lock counter=0, read tag pipeline cleared.
  - Reads in flight at reset are dropped; no rvalid ever appears for them.
- Grants are combinational from the requests and registered state. At most one gnt is high per cycle.
- An access is accepted at the rising edge that ends a cycle with req&gnt.
- Grant selection:
  - Locked (r_locked=1, counter<LOCK_MAX): only port 1 may be granted; o_p0_gnt=0 even if port 1 is idle.
  - Otherwise, one requester: grant it.
  - Otherwise, both requesters: grant the port != r_last.
- r_last is updated to the accepted port on every accept.
- Lock handling:
  - A port-1 accept with i_p1_lock=1 sets r_locked and increments the counter.
  - A port-1 accept with i_p1_lock=0 clears r_locked and the counter.
  - When counter==LOCK_MAX the lock is ignored for arbitration. If port 0 requests, it is granted. That port-0 accept clears r_locked and the counter.
- Memory command:
  - o_mem_en/wen/addr/wdata are combinational copies of the granted port's request in the grant cycle.
  - All are 0 when nothing is granted. o_mem_wen=0 for reads.
- Read return:
  - A read accepted in cycle k pushes {valid,id} into a READ_LAT-deep shift pipe.
  - In cycle k+READ_LAT, the matching port's rvalid=1 and its rdata=i_mem_rdata.
  - The other port's rdata is 0.
  - Writes produce no rvalid.
- Back-to-back accepts are legal every cycle; the pipe supports one read per cycle with no bubble.
- No reordering: a write then a read to the same address from either port are issued in accept order.
- Mid-lock reset returns the block to the unlocked state, with r_last=1.

Test Plan:
- Reset release, port 0 read addr 0x0010 with mem returning 0xBEEF (READ_LAT=1): o_p0_gnt=1 same cycle, o_p0_rvalid=1 and o_p0_rdata=0xBEEF one cycle later, o_p1_rvalid=0.
- Both ports request continuously for 4 cycles: grants alternate p0,p1,p0,p1; o_cpu_stall=1 exactly in the p1 cycles.
- Port 1 writes 0x1234 to 0x0020 with lock=1 for 3 accepts while port 0 requests: p0 gets no grant. Port 1 then accepts with lock=0; p0 is granted the next cycle.
- Port 1 keeps lock=1 and req=1 indefinitely, port 0 requesting, LOCK_MAX=16: p1 gets 16 accepts, p0 is granted on the 17th cycle, and the lock state is cleared.
- READ_LAT=3, alternating reads p0@0x0002 then p1@0x0004: rvalid appears in cycles k+3 and k+4 on the correct ports with the matching mem data.
- i_rst_n pulsed low while 2 reads are in flight (READ_LAT=3): no rvalid afterwards, all outputs 0 during reset, and the first tie after reset goes to p0.
